// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream (LEN_LO, LEN_HI, 4*N data bytes, CSUM),
// packs the data bytes little-endian into 32-bit words, writes each word to the CPU's
// instruction memory and releases the CPU from reset only once the XOR checksum matches.
module prog_loader #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_a,
  output logic [31:0]       imem_d,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  // Largest image that fits in imem, widened so a 16-bit length compares cleanly.
  localparam logic [16:0]     MAX_WORDS = 17'd1 << ADDR_W;
  localparam logic [ADDR_W:0] WORD_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [7:0]        len_lo;
  logic [ADDR_W:0]   n_words;
  logic [23:0]       word_buf;
  logic [7:0]        csum;
  logic              take;
  logic [15:0]       len_full;
  logic              last_word;

  assign take      = in_valid && in_ready;
  assign len_full  = {in_data, len_lo};
  assign last_word = ((words_loaded + WORD_ONE) == n_words);

  // Status flags for a given state, packed as {in_ready, busy, done, err, cpu_rst}.
  // Registered together with the state so every flag changes on the same edge.
  function automatic logic [4:0] flags_for(input state_t s);
    case (s)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK: flags_for = 5'b11001;
      S_DONE:                              flags_for = 5'b00100;
      S_ERR:                               flags_for = 5'b00011;
      default:                             flags_for = 5'b00001;
    endcase
  endfunction

  // Control FSM: state, registered status flags, word counter and the imem write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                                <= S_IDLE;
      {in_ready, busy, done, err, cpu_rst} <= flags_for(S_IDLE);
      imem_we                              <= 1'b0;
      imem_a                               <= '0;
      imem_d                               <= '0;
      words_loaded                         <= '0;
      byte_cnt                             <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          // A new load restarts from word 0; earlier imem contents are left alone.
          if (start) begin
            state                                <= S_LEN_LO;
            {in_ready, busy, done, err, cpu_rst} <= flags_for(S_LEN_LO);
            words_loaded                         <= '0;
            byte_cnt                             <= '0;
          end
        end
        S_LEN_LO: begin
          if (take) begin
            state                                <= S_LEN_HI;
            {in_ready, busy, done, err, cpu_rst} <= flags_for(S_LEN_HI);
          end
        end
        S_LEN_HI: begin
          if (take) begin
            byte_cnt <= '0;
            if ({1'b0, len_full} > MAX_WORDS) begin
              state                                <= S_ERR;
              {in_ready, busy, done, err, cpu_rst} <= flags_for(S_ERR);
            end else if (len_full == 16'd0) begin
              state                                <= S_CHECK;
              {in_ready, busy, done, err, cpu_rst} <= flags_for(S_CHECK);
            end else begin
              state                                <= S_DATA;
              {in_ready, busy, done, err, cpu_rst} <= flags_for(S_DATA);
            end
          end
        end
        S_DATA: begin
          if (take) begin
            byte_cnt <= byte_cnt + 2'd1;
            // The 4th byte completes a word: write it on this edge so the strobe
            // is high in the following cycle.
            if (byte_cnt == 2'd3) begin
              imem_we      <= 1'b1;
              imem_a       <= words_loaded[ADDR_W-1:0];
              imem_d       <= {in_data, word_buf};
              words_loaded <= words_loaded + WORD_ONE;
              if (last_word) begin
                state                                <= S_CHECK;
                {in_ready, busy, done, err, cpu_rst} <= flags_for(S_CHECK);
              end
            end
          end
        end
        S_CHECK: begin
          if (take) begin
            if (in_data == csum) begin
              state                                <= S_DONE;
              {in_ready, busy, done, err, cpu_rst} <= flags_for(S_DONE);
            end else begin
              state                                <= S_ERR;
              {in_ready, busy, done, err, cpu_rst} <= flags_for(S_ERR);
            end
          end
        end
        default: begin
          state                                <= S_IDLE;
          {in_ready, busy, done, err, cpu_rst} <= flags_for(S_IDLE);
        end
      endcase
    end
  end

  // Datapath: length capture, little-endian byte lanes and the running XOR checksum.
  always_ff @(posedge clk) begin
    if (state == S_LEN_LO && take) begin
      len_lo <= in_data;
    end
    if (state == S_LEN_HI && take) begin
      n_words <= len_full[ADDR_W:0];
    end
    if (start && (state == S_IDLE || state == S_DONE || state == S_ERR)) begin
      csum <= 8'h00;
    end else if (state == S_DATA && take) begin
      csum <= csum ^ in_data;
    end
    if (state == S_DATA && take) begin
      case (byte_cnt)
        2'd0:    word_buf[7:0]   <= in_data;
        2'd1:    word_buf[15:8]  <= in_data;
        2'd2:    word_buf[23:16] <= in_data;
        default: word_buf        <= word_buf;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: table of frames plus hand-written corner sequences.
// Expected imem writes (address, data, cycle) are pushed to a queue by a byte-level
// reference model as each byte is accepted, and popped when the DUT strobes imem_we.
module tb_prog_loader;

  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_a;
  logic [31:0]       imem_d;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_a       (imem_a),
    .imem_d       (imem_d),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_w;

  // Reference model state for the frame being sent.
  int          m_pos;
  int          m_n;
  logic [31:0] m_word;

  typedef struct {
    string        name;
    logic [95:0]  raw;
    int           nb;
    bit           gaps;
    bit           exp_done;
    bit           exp_err;
    int           exp_words;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: imem_a=0x%0h imem_d=0x%0h, none expected", imem_a, imem_d);
      end else begin
        mon_w = exp_q.pop_front();
        check("imem_a", 32'(imem_a), 32'(mon_w.addr));
        check("imem_d", imem_d, mon_w.data);
        check("we_cycle", 32'(cyc), 32'(mon_w.due));
      end
    end
  end

  task automatic model_accept(input logic [7:0] b, input int due);
    int  k;
    wr_t w;
    if (m_pos == 0) begin
      m_n = int'(b);
    end else if (m_pos == 1) begin
      m_n = m_n | (int'(b) << 8);
    end else if (m_n <= (1 << ADDR_W) && (m_pos - 2) < 4 * m_n) begin
      k = m_pos - 2;
      m_word[8*(k%4) +: 8] = b;
      if (k % 4 == 3) begin
        w.addr = k / 4;
        w.data = m_word;
        w.due  = due;
        exp_q.push_back(w);
      end
    end
    m_pos++;
  endtask

  // Called and returns at #1 after a rising edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    int due;
    ok  = 1'b0;
    due = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 16 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok  = 1'b1;
        due = cyc + 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout: byte 0x%02h not accepted in 16 cycles, required accept", b);
    end else begin
      model_accept(b, due);
    end
  endtask

  task automatic start_load(input string name);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m_pos = 0;
    m_n   = 0;
    @(negedge clk);
    check({name, ".busy_start"},  32'(busy),         32'd1);
    check({name, ".ready_start"}, 32'(in_ready),     32'd1);
    check({name, ".done_start"},  32'(done),         32'd0);
    check({name, ".err_start"},   32'(err),          32'd0);
    check({name, ".cpurst_start"},32'(cpu_rst),      32'd1);
    check({name, ".words_start"}, 32'(words_loaded), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic finish_check(input string name, input bit d, input bit e, input int w);
    @(negedge clk);
    check({name, ".done"},     32'(done),         32'(d));
    check({name, ".err"},      32'(err),          32'(e));
    check({name, ".cpu_rst"},  32'(cpu_rst),      32'(!d));
    check({name, ".busy"},     32'(busy),         32'd0);
    check({name, ".in_ready"}, 32'(in_ready),     32'd0);
    check({name, ".words"},    32'(words_loaded), 32'(w));
    @(negedge clk);
    check({name, ".pending_writes"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input string name, input logic [95:0] raw, input int nb,
                         input bit gaps, input bit d, input bit e, input int w);
    vt[i].name      = name;
    vt[i].raw       = raw;
    vt[i].nb        = nb;
    vt[i].gaps      = gaps;
    vt[i].exp_done  = d;
    vt[i].exp_err   = e;
    vt[i].exp_words = w;
  endtask

  task automatic send_basic(input bit gaps);
    logic [87:0] f;
    f = 88'h02_00_78_56_34_12_EF_BE_AD_DE_2A;
    for (int j = 0; j < 11; j++) send_byte(f[(10-j)*8 +: 8], gaps);
  endtask

  initial begin
    logic [95:0] raw;
    logic [7:0]  cs;
    logic [7:0]  b;

    set_vec(0, "basic",     96'h02_00_78_56_34_12_EF_BE_AD_DE_2A, 11, 1'b0, 1'b1, 1'b0, 2);
    set_vec(1, "bad_csum",  96'h02_00_78_56_34_12_EF_BE_AD_DE_2B, 11, 1'b0, 1'b0, 1'b1, 2);
    set_vec(2, "empty",     96'h00_00_00,                          3, 1'b0, 1'b1, 1'b0, 0);
    set_vec(3, "too_long",  96'h01_02,                             2, 1'b0, 1'b0, 1'b1, 0);
    set_vec(4, "gaps",      96'h02_00_78_56_34_12_EF_BE_AD_DE_2A, 11, 1'b1, 1'b1, 1'b0, 2);
    set_vec(5, "one_word",  96'h01_00_11_22_33_44_44,              7, 1'b0, 1'b1, 1'b0, 1);
    set_vec(6, "empty_bad", 96'h00_00_01,                          3, 1'b0, 1'b0, 1'b1, 0);

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    m_pos    = 0;
    m_n      = 0;
    m_word   = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.in_ready", 32'(in_ready),     32'd0);
    check("rst.imem_we",  32'(imem_we),      32'd0);
    check("rst.imem_a",   32'(imem_a),       32'd0);
    check("rst.imem_d",   imem_d,            32'd0);
    check("rst.busy",     32'(busy),         32'd0);
    check("rst.done",     32'(done),         32'd0);
    check("rst.err",      32'(err),          32'd0);
    check("rst.words",    32'(words_loaded), 32'd0);
    check("rst.cpu_rst",  32'(cpu_rst),      32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      start_load(vt[i].name);
      raw = vt[i].raw;
      for (int j = 0; j < vt[i].nb; j++) send_byte(raw[(vt[i].nb-1-j)*8 +: 8], vt[i].gaps);
      finish_check(vt[i].name, vt[i].exp_done, vt[i].exp_err, vt[i].exp_words);
    end

    // start pulsed mid-load must be ignored.
    start_load("start_ignored");
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h44, 1'b0);
    finish_check("start_ignored", 1'b1, 1'b0, 1);

    // Reset after 5 data bytes, then a clean full load.
    start_load("mid_rst");
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'hEF, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst.in_ready", 32'(in_ready),     32'd0);
    check("mid_rst.busy",     32'(busy),         32'd0);
    check("mid_rst.words",    32'(words_loaded), 32'd0);
    check("mid_rst.cpu_rst",  32'(cpu_rst),      32'd1);
    check("mid_rst.done",     32'(done),         32'd0);
    check("mid_rst.err",      32'(err),          32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_load("after_rst");
    send_basic(1'b0);
    finish_check("after_rst", 1'b1, 1'b0, 2);

    // Largest image that still fits: N = 2**ADDR_W words.
    start_load("full_mem");
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    cs = 8'h00;
    for (int i = 0; i < 4 * (1 << ADDR_W); i++) begin
      b  = 8'((i * 7 + 3) & 255);
      cs = cs ^ b;
      send_byte(b, 1'b0);
    end
    send_byte(cs, 1'b0);
    finish_check("full_mem", 1'b1, 1'b0, 1 << ADDR_W);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
